// File: rtl/morse_key_decoder.sv
// Morse keypad decoder: turns keypad releases into dots/dashes, decodes the
// buffered pattern to ASCII on commit and hands it out on a valid/ready port.
module morse_key_decoder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [3:0] KEY_DOT     = 4'h0,
  parameter logic [3:0] KEY_DASH    = 4'h1,
  parameter logic [3:0] KEY_COMMIT  = 4'hE,
  parameter logic [3:0] KEY_CLEAR   = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_val,
  input  logic       key_flag,
  input  logic       char_ready,
  output logic [7:0] char_data,
  output logic       char_valid,
  output logic       char_err,
  output logic [2:0] sym_len,
  output logic [4:0] sym_code,
  output logic       key_drop
);

  typedef enum logic [1:0] {S_EMPTY, S_COLLECT, S_OVF, S_OUT} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   flag_s;
  logic                   flag_prev_q;
  logic [3:0]             key_lat_q;
  logic                   ev_q;
  logic [3:0]             ev_key_q;

  state_t     state_q, state_d;
  logic [2:0] sym_len_q, sym_len_d;
  logic [4:0] sym_code_q, sym_code_d;
  logic [7:0] char_data_q, char_data_d;
  logic       char_err_q, char_err_d;
  logic       char_valid_q, char_valid_d;
  logic       key_drop_q, key_drop_d;

  logic is_sym, is_commit, is_clear, sym_bit;

  // Returns {err, ascii}; unknown patterns decode to '?' with err set.
  function automatic logic [8:0] lookup(input logic [2:0] len, input logic [4:0] code);
    logic [7:0] k;
    k = {len, code};
    case (k)
      {3'd1, 5'b00000}: lookup = {1'b0, 8'h45};
      {3'd1, 5'b00001}: lookup = {1'b0, 8'h54};
      {3'd2, 5'b00000}: lookup = {1'b0, 8'h49};
      {3'd2, 5'b00001}: lookup = {1'b0, 8'h41};
      {3'd2, 5'b00010}: lookup = {1'b0, 8'h4E};
      {3'd2, 5'b00011}: lookup = {1'b0, 8'h4D};
      {3'd3, 5'b00000}: lookup = {1'b0, 8'h53};
      {3'd3, 5'b00001}: lookup = {1'b0, 8'h55};
      {3'd3, 5'b00010}: lookup = {1'b0, 8'h52};
      {3'd3, 5'b00011}: lookup = {1'b0, 8'h57};
      {3'd3, 5'b00100}: lookup = {1'b0, 8'h44};
      {3'd3, 5'b00101}: lookup = {1'b0, 8'h4B};
      {3'd3, 5'b00110}: lookup = {1'b0, 8'h47};
      {3'd3, 5'b00111}: lookup = {1'b0, 8'h4F};
      {3'd4, 5'b00000}: lookup = {1'b0, 8'h48};
      {3'd4, 5'b00001}: lookup = {1'b0, 8'h56};
      {3'd4, 5'b00010}: lookup = {1'b0, 8'h46};
      {3'd4, 5'b00100}: lookup = {1'b0, 8'h4C};
      {3'd4, 5'b00110}: lookup = {1'b0, 8'h50};
      {3'd4, 5'b00111}: lookup = {1'b0, 8'h4A};
      {3'd4, 5'b01000}: lookup = {1'b0, 8'h42};
      {3'd4, 5'b01001}: lookup = {1'b0, 8'h58};
      {3'd4, 5'b01010}: lookup = {1'b0, 8'h43};
      {3'd4, 5'b01011}: lookup = {1'b0, 8'h59};
      {3'd4, 5'b01100}: lookup = {1'b0, 8'h5A};
      {3'd4, 5'b01101}: lookup = {1'b0, 8'h51};
      {3'd5, 5'b11111}: lookup = {1'b0, 8'h30};
      {3'd5, 5'b01111}: lookup = {1'b0, 8'h31};
      {3'd5, 5'b00111}: lookup = {1'b0, 8'h32};
      {3'd5, 5'b00011}: lookup = {1'b0, 8'h33};
      {3'd5, 5'b00001}: lookup = {1'b0, 8'h34};
      {3'd5, 5'b00000}: lookup = {1'b0, 8'h35};
      {3'd5, 5'b10000}: lookup = {1'b0, 8'h36};
      {3'd5, 5'b11000}: lookup = {1'b0, 8'h37};
      {3'd5, 5'b11100}: lookup = {1'b0, 8'h38};
      {3'd5, 5'b11110}: lookup = {1'b0, 8'h39};
      default:          lookup = {1'b1, 8'h3F};
    endcase
  endfunction

  assign flag_s = sync_q[SYNC_STAGES-1];

  // Synchronizer, key latch and release detection; the event is registered
  // once more so the FSM acts SYNC_STAGES+1 edges after the flag is seen low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      flag_prev_q <= 1'b0;
      key_lat_q   <= 4'h0;
      ev_q        <= 1'b0;
      ev_key_q    <= 4'h0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], key_flag};
      flag_prev_q <= flag_s;
      if (flag_s) key_lat_q <= key_val;
      ev_q        <= flag_prev_q & ~flag_s;
      ev_key_q    <= key_lat_q;
    end
  end

  assign is_sym    = ev_q && ((ev_key_q == KEY_DOT) || (ev_key_q == KEY_DASH));
  assign sym_bit   = (ev_key_q == KEY_DASH);
  assign is_commit = ev_q && (ev_key_q == KEY_COMMIT);
  assign is_clear  = ev_q && (ev_key_q == KEY_CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      sym_len_q    <= 3'd0;
      sym_code_q   <= 5'd0;
      char_data_q  <= 8'h00;
      char_err_q   <= 1'b0;
      char_valid_q <= 1'b0;
      key_drop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sym_len_q    <= sym_len_d;
      sym_code_q   <= sym_code_d;
      char_data_q  <= char_data_d;
      char_err_q   <= char_err_d;
      char_valid_q <= char_valid_d;
      key_drop_q   <= key_drop_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sym_len_d    = sym_len_q;
    sym_code_d   = sym_code_q;
    char_data_d  = char_data_q;
    char_err_d   = char_err_q;
    char_valid_d = char_valid_q;
    key_drop_d   = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (is_sym) begin
          sym_len_d  = 3'd1;
          sym_code_d = {4'b0000, sym_bit};
          state_d    = S_COLLECT;
        end else if (is_commit) begin
          char_data_d  = 8'h20;
          char_err_d   = 1'b0;
          char_valid_d = 1'b1;
          state_d      = S_OUT;
        end
      end
      S_COLLECT: begin
        if (is_sym) begin
          if (sym_len_q < 3'd5) begin
            sym_code_d = {sym_code_q[3:0], sym_bit};
            sym_len_d  = sym_len_q + 3'd1;
          end else begin
            state_d = S_OVF;
          end
        end else if (is_commit) begin
          {char_err_d, char_data_d} = lookup(sym_len_q, sym_code_q);
          char_valid_d = 1'b1;
          sym_len_d    = 3'd0;
          sym_code_d   = 5'd0;
          state_d      = S_OUT;
        end else if (is_clear) begin
          sym_len_d  = 3'd0;
          sym_code_d = 5'd0;
          state_d    = S_EMPTY;
        end
      end
      S_OVF: begin
        if (is_commit) begin
          char_data_d  = 8'h3F;
          char_err_d   = 1'b1;
          char_valid_d = 1'b1;
          sym_len_d    = 3'd0;
          sym_code_d   = 5'd0;
          state_d      = S_OUT;
        end else if (is_clear) begin
          sym_len_d  = 3'd0;
          sym_code_d = 5'd0;
          state_d    = S_EMPTY;
        end
      end
      S_OUT: begin
        // Keys pressed while a character is pending are dropped, even on the handshake edge.
        if (is_sym || is_commit || is_clear) key_drop_d = 1'b1;
        if (char_valid_q && char_ready) begin
          char_valid_d = 1'b0;
          state_d      = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    char_data  = char_data_q;
    char_valid = char_valid_q;
    char_err   = char_err_q;
    sym_len    = sym_len_q;
    sym_code   = sym_code_q;
    key_drop   = key_drop_q;
  end

endmodule

// File: tb/tb_morse_key_decoder.sv
// Directed and randomized bench for morse_key_decoder with a string-based Morse model.
`timescale 1ns/1ps
module tb_morse_key_decoder;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_val = 4'h0;
  logic       key_flag = 1'b0;
  logic       char_ready = 1'b0;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_err;
  logic [2:0] sym_len;
  logic [4:0] sym_code;
  logic       key_drop;

  int passed = 0;
  int total  = 0;

  morse_key_decoder #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .key_val(key_val), .key_flag(key_flag),
    .char_ready(char_ready), .char_data(char_data), .char_valid(char_valid),
    .char_err(char_err), .sym_len(sym_len), .sym_code(sym_code), .key_drop(key_drop)
  );

  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: symbols kept as a string of '.' and '-'.
  string pat [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                      ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                      "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                      "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                      "--...", "---..", "----."};
  string alph = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
  string m_syms;
  bit    m_ovf, m_busy, m_err;
  byte   m_char;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic press(input logic [3:0] k, input int hold);
    @(posedge clk); #1;
    key_val  = k;
    key_flag = 1'b1;
    repeat (hold) @(posedge clk);
    #1 key_flag = 1'b0;
    repeat (SYNC + 2) @(posedge clk);
    #1;
  endtask

  task automatic model_key(input logic [3:0] k, output bit drop);
    drop = 1'b0;
    if (k != 4'h0 && k != 4'h1 && k != 4'hE && k != 4'hF) return;
    if (m_busy) begin
      drop = 1'b1;
      return;
    end
    if (k == 4'h0 || k == 4'h1) begin
      if (!m_ovf) begin
        if (m_syms.len() < 5) begin
          if (k == 4'h1) m_syms = {m_syms, "-"};
          else           m_syms = {m_syms, "."};
        end else m_ovf = 1'b1;
      end
    end else if (k == 4'hF) begin
      m_syms = "";
      m_ovf  = 1'b0;
    end else begin
      if (m_ovf) begin
        m_char = 8'h3F; m_err = 1'b1;
      end else if (m_syms.len() == 0) begin
        m_char = 8'h20; m_err = 1'b0;
      end else begin
        m_char = 8'h3F; m_err = 1'b1;
        for (int i = 0; i < 36; i++)
          if (pat[i] == m_syms) begin
            m_char = alph[i]; m_err = 1'b0;
          end
      end
      m_busy = 1'b1;
      m_syms = "";
      m_ovf  = 1'b0;
    end
  endtask

  task automatic check_model(input string tag, input bit drop);
    logic [4:0] code;
    code = 5'd0;
    for (int i = 0; i < m_syms.len(); i++) code = {code[3:0], m_syms[i] == 8'h2D};
    chk({tag, ".len"},   {29'd0, sym_len}, m_syms.len());
    chk({tag, ".code"},  {27'd0, sym_code}, {27'd0, code});
    chk({tag, ".valid"}, {31'd0, char_valid}, {31'd0, m_busy});
    chk({tag, ".data"},  {24'd0, char_data}, {24'd0, m_char});
    chk({tag, ".err"},   {31'd0, char_err}, {31'd0, m_err});
    chk({tag, ".drop"},  {31'd0, key_drop}, {31'd0, drop});
  endtask

  initial begin
    logic [3:0] k;
    bit         drop;
    int         r;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", {31'd0, char_valid}, 0);
    chk("rst.data",  {24'd0, char_data}, 0);
    chk("rst.len",   {29'd0, sym_len}, 0);
    chk("rst.drop",  {31'd0, key_drop}, 0);
    rst = 1'b0;
    char_ready = 1'b1;

    // Release latency: first low sample at e0, update exactly at e0+SYNC+1
    @(posedge clk); #1;
    key_val = 4'h0; key_flag = 1'b1;
    repeat (5) @(posedge clk);
    #1 key_flag = 1'b0;
    repeat (SYNC + 1) @(posedge clk);
    #1 chk("timing.before", {29'd0, sym_len}, 0);
    @(posedge clk);
    #1 chk("timing.at", {29'd0, sym_len}, 1);
    chk("dot.code", {27'd0, sym_code}, 5'b00000);
    press(4'h1, 5);
    chk("dash.len",  {29'd0, sym_len}, 2);
    chk("dash.code", {27'd0, sym_code}, 5'b00001);
    press(4'hE, 5);
    chk("A.valid", {31'd0, char_valid}, 1);
    chk("A.data",  {24'd0, char_data}, 8'h41);
    chk("A.err",   {31'd0, char_err}, 0);
    chk("A.len",   {29'd0, sym_len}, 0);
    @(posedge clk); #1;
    chk("A.valid_drop", {31'd0, char_valid}, 0);
    chk("A.data_hold",  {24'd0, char_data}, 8'h41);

    // Five dashes -> '0'
    repeat (5) press(4'h1, 4);
    chk("five.len",  {29'd0, sym_len}, 5);
    chk("five.code", {27'd0, sym_code}, 5'b11111);
    press(4'hE, 4);
    chk("zero.data", {24'd0, char_data}, 8'h30);
    chk("zero.err",  {31'd0, char_err}, 0);

    // .-.- is not in the table
    press(4'h0, 4); press(4'h1, 4); press(4'h0, 4); press(4'h1, 4);
    press(4'hE, 4);
    chk("miss.data", {24'd0, char_data}, 8'h3F);
    chk("miss.err",  {31'd0, char_err}, 1);

    // Overflow: six dots
    repeat (6) press(4'h0, 4);
    chk("ovf.len",  {29'd0, sym_len}, 5);
    chk("ovf.drop", {31'd0, key_drop}, 0);
    press(4'hE, 4);
    chk("ovf.data", {24'd0, char_data}, 8'h3F);
    chk("ovf.err",  {31'd0, char_err}, 1);
    press(4'h0, 4);
    press(4'hF, 4);
    chk("clr.len",  {29'd0, sym_len}, 0);
    chk("clr.code", {27'd0, sym_code}, 0);
    press(4'hE, 4);
    chk("space.data", {24'd0, char_data}, 8'h20);
    chk("space.err",  {31'd0, char_err}, 0);
    press(4'h7, 4);
    chk("unmapped.len",  {29'd0, sym_len}, 0);
    chk("unmapped.drop", {31'd0, key_drop}, 0);

    // Back-pressure and dropped key
    char_ready = 1'b0;
    press(4'h0, 4);
    press(4'hE, 4);
    repeat (3) @(posedge clk);
    #1;
    chk("bp.valid", {31'd0, char_valid}, 1);
    chk("bp.data",  {24'd0, char_data}, 8'h45);
    press(4'h1, 4);
    chk("bp.drop",  {31'd0, key_drop}, 1);
    chk("bp.len",   {29'd0, sym_len}, 0);
    chk("bp.valid2", {31'd0, char_valid}, 1);
    @(posedge clk); #1;
    chk("bp.drop_pulse", {31'd0, key_drop}, 0);
    char_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.release", {31'd0, char_valid}, 0);
    char_ready = 1'b0;

    // Asynchronous reset while a character is pending
    press(4'h1, 4);
    press(4'hE, 4);
    chk("arst.pre", {31'd0, char_valid}, 1);
    rst = 1'b1;
    #1;
    chk("arst.valid", {31'd0, char_valid}, 0);
    chk("arst.data",  {24'd0, char_data}, 0);
    chk("arst.err",   {31'd0, char_err}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomized sequence against the model
    m_syms = ""; m_ovf = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_char = 8'h00;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: k = 4'h0;
        3, 4, 5: k = 4'h1;
        6, 9:    k = 4'hE;
        7:       k = 4'hF;
        default: k = 4'($urandom_range(2, 13));
      endcase
      press(k, $urandom_range(4, 8));
      model_key(k, drop);
      check_model($sformatf("rnd%0d", n), drop);
      if (m_busy && ($urandom_range(0, 1) == 1)) begin
        char_ready = 1'b1;
        @(posedge clk); #1;
        char_ready = 1'b0;
        m_busy = 1'b0;
        check_model($sformatf("rnd%0d.hs", n), 1'b0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/morse_key_decoder.md
Name: morse_key_decoder

Overview:
Consumes the 4x4 keypad scanner outputs (4-bit key value plus pressed flag) and turns key releases into Morse symbols: dot, dash, commit-letter, clear. Accumulates up to 5 symbols, decodes the pattern to ASCII on commit, and presents the character on a valid/ready output toward the display/text-buffer stage. Also exposes the in-progress symbol buffer for live display.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the key_flag synchronizer (minimum 2).
KEY_DOT, 4'h0, key value that enters a dot.
KEY_DASH, 4'h1, key value that enters a dash.
KEY_COMMIT, 4'hE, key value that ends the letter and triggers decode.
KEY_CLEAR, 4'hF, key value that discards the in-progress buffer.

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  reset, asynchronous, active-high
key_val  in  4  keypad value from the scanner
key_flag  in  1  keypad pressed flag from the scanner (level, slow)
char_ready  in  1  downstream accepts char_data when high with char_valid
char_data  out  8  decoded ASCII character
char_valid  out  1  char_data valid; held until char_ready
char_err  out  1  qualifies char_data: pattern invalid or overflowed
sym_len  out  3  symbols currently buffered (0..5)
sym_code  out  5  buffered pattern, right-aligned, first symbol most significant; 1=dash, 0=dot
key_drop  out  1  one-cycle pulse: key event discarded

Behaviour:
- Reset (async): all outputs 0, state S_EMPTY, synchronizer and key latch cleared to 0 (flag treated as released).
- key_flag passes through a SYNC_STAGES synchronizer. key_val is latched on every clk where the synchronized flag is high. The last latched value is used on release, because the scanner's value lags its flag.
- Key event = falling edge of the synchronized flag. State and output registers update at the (SYNC_STAGES+1)th clk edge after the first edge that samples key_flag low. Holding a key produces exactly one event, on release.
- Unmapped key values: event ignored, no key_drop.
- States: S_EMPTY, S_COLLECT, S_OVF, S_OUT.
- S_EMPTY:
  - dot/dash -> sym_len=1, sym_code={4'b0,sym}, go S_COLLECT.
  - commit -> char_data=8'h20 (space), char_err=0, go S_OUT.
  - clear -> stay.
- S_COLLECT:
  - dot/dash with sym_len<5 -> sym_code={sym_code[3:0],sym}, sym_len+1.
  - dot/dash with sym_len==5 -> go S_OVF; buffer unchanged.
  - commit -> look up {sym_len,sym_code}; go S_OUT.
  - clear -> sym_len=0, sym_code=0, go S_EMPTY.
- Lookup: A-Z use the ITU patterns (1-4 symbols); 0-9 use the 5-symbol patterns. Hit -> char_data = uppercase ASCII, char_err=0. Miss -> char_data=8'h3F ('?'), char_err=1.
- S_OVF: dot/dash ignored (no key_drop). commit -> char_data=8'h3F, char_err=1, go S_OUT. clear -> S_EMPTY with buffer zeroed.
- S_OUT:
  - char_valid=1; char_data and char_err held stable.
  - On entry, sym_len and sym_code are cleared in the same edge as char_valid rises.
  - Handshake completes on the edge where char_valid&char_ready -> char_valid=0 next cycle, go S_EMPTY.
  - Any key event while in S_OUT is discarded and key_drop pulses one cycle.
  - If the event and the handshake fall on the same edge, the event is still dropped.
- char_ready is ignored when char_valid=0. char_data keeps its last value after handshake.
- Reset mid-operation: immediate return to the reset state; a pending char is lost. A key still held at reset release produces an event on its release; its latched value comes from cycles after reset.

Test Plan:
- Release '0', then '1', then 'E' (each press ≥4 clks, char_ready=1): after '0', sym_len=1, sym_code=5'b00000; after '1', sym_len=2, sym_code=5'b00001; after 'E', char_valid pulses one cycle with char_data=8'h41 ('A'), char_err=0, sym_len=0.
- Press 1,1,1,1,1 then E: sym_len=5, sym_code=5'b11111 -> char_data=8'h30 ('0'), char_err=0.
- Press 0,1,0,1 then E (4-symbol pattern outside the table): char_data=8'h3F, char_err=1.
- Press six dots then E: state S_OVF after the 6th, sym_len stays 5 -> char_data=8'h3F, char_err=1. Press 0,F: buffer cleared, sym_len=0. Press E alone: char_data=8'h20.
- With char_ready=0, press 0 then E -> char_valid stays high with 'E' (8'h45). Press 1 -> key_drop pulses, sym_len stays 0. Raise char_ready -> char_valid drops next cycle.
- Timing: key_flag falls at edge k -> sym_len updates exactly at edge k+SYNC_STAGES+1. Assert rst while char_valid=1 -> all outputs 0 immediately.
